// File: rtl/vinc_wb_queue.sv
// rtl/vinc_wb_queue.sv - write-back queue feeding port c of the vector inc register file
module vinc_wb_queue #(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 8,
    parameter int LOG2NUMREGS = 3,
    parameter int DEPTH       = 4,
    parameter int LOG2DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LOG2NUMREGS-1:0] in_reg,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   wr_stall,
    output logic [LOG2NUMREGS-1:0] c_reg,
    output logic [WIDTH-1:0]       c_writedatain,
    output logic                   c_we,
    input  logic                   chk_en,
    input  logic [LOG2NUMREGS-1:0] chk_reg,
    output logic                   chk_hit,
    output logic [LOG2DEPTH:0]     count,
    output logic                   empty
);

    localparam logic [LOG2DEPTH:0] CNT_FULL = (LOG2DEPTH + 1)'(DEPTH);

    if (NUMREGS > (1 << LOG2NUMREGS) || DEPTH != (1 << LOG2DEPTH) || DEPTH < 2) begin : g_param_check
        $error("vinc_wb_queue: inconsistent parameters");
    end

    logic [LOG2NUMREGS-1:0] q_reg  [DEPTH];
    logic [WIDTH-1:0]       q_data [DEPTH];
    logic [LOG2DEPTH-1:0]   rd_ptr;
    logic [LOG2DEPTH-1:0]   wr_ptr;
    logic                   enq;
    logic                   deq;
    logic                   q_hit;

    assign in_ready = (count < CNT_FULL);
    // inc0 is hardwired to zero, so its writes complete the handshake but are never stored
    assign enq      = in_valid & in_ready & (in_reg != '0);
    assign deq      = (count != '0) & ~wr_stall;
    assign empty    = (count == '0) & ~c_we;

    always_ff @(posedge clk) begin
        if (enq) begin
            q_reg[wr_ptr]  <= in_reg;
            q_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            c_we          <= 1'b0;
            c_reg         <= '0;
            c_writedatain <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                c_reg         <= q_reg[rd_ptr];
                c_writedatain <= q_data[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end
            c_we <= deq;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from rd_ptr (modulo DEPTH) is below count
    always_comb begin
        logic [LOG2DEPTH-1:0] offset;
        offset = '0;
        q_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = LOG2DEPTH'(i) - rd_ptr;
            if (({1'b0, offset} < count) && (q_reg[i] == chk_reg)) begin
                q_hit = 1'b1;
            end
        end
    end

    assign chk_hit = chk_en & (chk_reg != '0) & ((c_we & (c_reg == chk_reg)) | q_hit);

endmodule

// File: tb/tb_vinc_wb_queue.sv
// tb/tb_vinc_wb_queue.sv - scoreboard bench for vinc_wb_queue
module tb_vinc_wb_queue;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_reg;
    logic [31:0] in_data;
    logic        wr_stall;
    logic [2:0]  c_reg;
    logic [31:0] c_writedatain;
    logic        c_we;
    logic        chk_en;
    logic [2:0]  chk_reg;
    logic        chk_hit;
    logic [2:0]  count;
    logic        empty;

    int n_total = 0;
    int n_pass  = 0;
    logic [34:0] sb[$];

    vinc_wb_queue dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .wr_stall(wr_stall), .c_reg(c_reg),
        .c_writedatain(c_writedatain), .c_we(c_we), .chk_en(chk_en), .chk_reg(chk_reg),
        .chk_hit(chk_hit), .count(count), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Writes seen on port c are popped from the scoreboard; the following edge's handshake is pushed
    always @(negedge clk) begin
        logic [34:0] exp;
        if (c_we === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL port_c_unexpected: got reg=%0d data=%h, required no write", c_reg, c_writedatain);
            end else begin
                exp = sb.pop_front();
                if ({c_reg, c_writedatain} !== exp)
                    $display("FAIL port_c_order: got reg=%0d data=%h, required reg=%0d data=%h",
                             c_reg, c_writedatain, exp[34:32], exp[31:0]);
                else
                    n_pass++;
            end
        end
        if (resetn === 1'b0)
            sb.delete();
        else if (in_valid && in_ready === 1'b1 && in_reg != 3'd0)
            sb.push_back({in_reg, in_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input string name);
        int cyc = 0;
        while (!(empty === 1'b1 && sb.size() == 0) && cyc < 50) begin
            step();
            cyc++;
        end
        n_total++;
        if (empty === 1'b1 && sb.size() == 0) n_pass++;
        else $display("FAIL %s_drain: empty=%b pending=%0d after %0d cycles, required drained", name, empty, sb.size(), cyc);
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
        wr_stall = 1'b0; chk_en = 1'b0; chk_reg = '0;
        step(); step();
        resetn = 1'b1;
        n_total++;
        if ({in_ready, empty, c_we, count} !== {1'b1, 1'b1, 1'b0, 3'd0})
            $display("FAIL reset_state: in_ready=%b empty=%b c_we=%b count=%0d, required 1 1 0 0", in_ready, empty, c_we, count);
        else n_pass++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_reg = 3'd3; in_data = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        n_total++;
        if (c_we !== 1'b0 || count !== 3'd1)
            $display("FAIL single_accept: c_we=%b count=%0d, required 0 1", c_we, count);
        else n_pass++;
        step();
        n_total++;
        if ({c_we, c_reg, c_writedatain} !== {1'b1, 3'd3, 32'hDEADBEEF})
            $display("FAIL single_latency: c_we=%b reg=%0d data=%h, required 1 3 deadbeef", c_we, c_reg, c_writedatain);
        else n_pass++;
        step();
        n_total++;
        if (c_we !== 1'b0 || empty !== 1'b1)
            $display("FAIL single_pulse: c_we=%b empty=%b, required 0 1", c_we, empty);
        else n_pass++;
    endtask

    task automatic test_inc0();
        in_valid = 1'b1; in_reg = 3'd0; in_data = 32'h1234;
        chk_en = 1'b1; chk_reg = 3'd0;
        #1;
        n_total++;
        if (in_ready !== 1'b1 || chk_hit !== 1'b0)
            $display("FAIL inc0_ready: in_ready=%b chk_hit=%b, required 1 0", in_ready, chk_hit);
        else n_pass++;
        step();
        in_valid = 1'b0; chk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (count !== 3'd0 || c_we !== 1'b0)
                $display("FAIL inc0_drop: count=%0d c_we=%b, required 0 0", count, c_we);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_fill_stall();
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = 3'(i + 1); in_data = 32'h10 + 32'(i);
            step();
        end
        in_reg = 3'd5; in_data = 32'h14;
        n_total++;
        if (count !== 3'd4 || in_ready !== 1'b0)
            $display("FAIL fill_full: count=%0d in_ready=%b, required 4 0", count, in_ready);
        else n_pass++;
        step(); step();
        n_total++;
        if (count !== 3'd4)
            $display("FAIL fill_blocked: count=%0d, required 4", count);
        else n_pass++;
        in_valid = 1'b0; wr_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (c_we !== 1'b1 || c_reg !== 3'(i + 1) || count !== 3'(3 - i) || in_ready !== 1'b1)
                $display("FAIL fill_drain_%0d: c_we=%b reg=%0d count=%0d in_ready=%b, required 1 %0d %0d 1",
                         i, c_we, c_reg, count, in_ready, i + 1, 3 - i);
            else n_pass++;
        end
        step();
        n_total++;
        if (c_we !== 1'b0)
            $display("FAIL fill_end: c_we=%b, required 0", c_we);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        wr_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_reg = 3'(i + 1); in_data = $urandom;
            step();
        end
        wr_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_reg = 3'((i % 7) + 1); in_data = $urandom;
            step();
            n_total++;
            if (count !== 3'd2)
                $display("FAIL b2b_count_%0d: count=%0d, required 2", i, count);
            else n_pass++;
        end
        in_valid = 1'b0;
        wait_drained("b2b");
    endtask

    task automatic test_hazard();
        wr_stall = 1'b1; chk_en = 1'b1; chk_reg = 3'd6;
        in_valid = 1'b1; in_reg = 3'd6; in_data = 32'h66;
        #1;
        n_total++;
        if (chk_hit !== 1'b0)
            $display("FAIL hazard_inport: chk_hit=%b, required 0", chk_hit);
        else n_pass++;
        in_reg = 3'd5; in_data = 32'h55;
        step();
        in_valid = 1'b0;
        chk_reg = 3'd5; #1;
        n_total++;
        if (chk_hit !== 1'b1)
            $display("FAIL hazard_hit: chk_hit=%b, required 1", chk_hit);
        else n_pass++;
        chk_reg = 3'd6; #1;
        n_total++;
        if (chk_hit !== 1'b0)
            $display("FAIL hazard_miss: chk_hit=%b, required 0", chk_hit);
        else n_pass++;
        chk_reg = 3'd5; chk_en = 1'b0; #1;
        n_total++;
        if (chk_hit !== 1'b0)
            $display("FAIL hazard_disabled: chk_hit=%b, required 0", chk_hit);
        else n_pass++;
        chk_en = 1'b1; wr_stall = 1'b0;
        step();
        n_total++;
        if ({c_we, c_reg, count, chk_hit} !== {1'b1, 3'd5, 3'd0, 1'b1})
            $display("FAIL hazard_inflight: c_we=%b reg=%0d count=%0d chk_hit=%b, required 1 5 0 1", c_we, c_reg, count, chk_hit);
        else n_pass++;
        step();
        n_total++;
        if (empty !== 1'b1 || chk_hit !== 1'b0)
            $display("FAIL hazard_clear: empty=%b chk_hit=%b, required 1 0", empty, chk_hit);
        else n_pass++;
        chk_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = 3'(i + 1); in_data = 32'hA0 + 32'(i);
            step();
        end
        in_valid = 1'b0; wr_stall = 1'b0;
        step();
        n_total++;
        if (c_we !== 1'b1 || count !== 3'd3)
            $display("FAIL rstmid_setup: c_we=%b count=%0d, required 1 3", c_we, count);
        else n_pass++;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        n_total++;
        if ({c_we, count, empty} !== {1'b0, 3'd0, 1'b1})
            $display("FAIL rstmid_state: c_we=%b count=%0d empty=%b, required 0 0 1", c_we, count, empty);
        else n_pass++;
        for (int i = 0; i < 8; i++) step();
        n_total++;
        if (empty !== 1'b1)
            $display("FAIL rstmid_quiet: empty=%b, required 1", empty);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_inc0();
        test_fill_stall();
        test_back_to_back();
        test_hazard();
        test_reset_mid();
        n_total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_leftover: pending=%0d, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vinc_wb_queue.md
Name: vinc_wb_queue

Overview:
- Write-side front end for the vector inc register file, which has one write port (c) and one read port (a).
- Accepts inc register write requests from the vector pipeline, buffers them in a small FIFO, and drives one write per cycle onto the regfile c port.
- Reports pending-write hazards so the reader can stall. This is needed because the RAM read address is registered and mixed-port read-during-write returns OLD_DATA.
- Writes to inc0 are dropped at the input; inc0 is fixed to 0.

Parameters:
- WIDTH, 32, data width of one inc register.
- NUMREGS, 8, number of inc registers.
- LOG2NUMREGS, 3, register index width.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- LOG2DEPTH, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  write request valid.
- in_ready  out  1  queue can accept a request.
- in_reg  in  LOG2NUMREGS  destination inc register.
- in_data  in  WIDTH  write data.
- wr_stall  in  1  regfile write port unavailable this cycle; no dequeue.
- c_reg  out  LOG2NUMREGS  write address to regfile port c (registered).
- c_writedatain  out  WIDTH  write data to regfile port c (registered).
- c_we  out  1  write enable to regfile port c (registered, one-cycle pulse per write).
- chk_en  in  1  hazard lookup enable.
- chk_reg  in  LOG2NUMREGS  register the reader is about to read.
- chk_hit  out  1  pending write to chk_reg exists (combinational).
- count  out  LOG2DEPTH+1  number of queued entries; excludes the output register.
- empty  out  1  count==0 and c_we==0.

Behaviour:
- Reset: when resetn=0 at a clock edge, the following are cleared: rd_ptr, wr_ptr, count, c_we, c_reg, c_writedatain. Queue contents are don't-care. Reset overrides any in-progress enqueue or dequeue; pending entries are discarded. After reset, in_ready=1 and empty=1.
- in_ready = (count < DEPTH). It does not depend on a same-cycle dequeue.
- Accept: an edge with in_valid & in_ready counts as a handshake.
  - If in_reg != 0, the entry {in_reg, in_data} is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - If in_reg == 0, the handshake completes but nothing is enqueued.
- Dequeue: at each edge with count>0 and wr_stall=0, the head entry loads the output register, c_we becomes 1 for the next cycle, and rd_ptr increments with wrap.
- No dequeue: if count==0 or wr_stall=1, c_we becomes 0 next cycle. c_reg and c_writedatain hold their previous values.
- A write is never issued twice.
- Count update: +1 on an enqueue only, -1 on a dequeue only, unchanged on simultaneous enqueue and dequeue.
  - With count==DEPTH, enqueue is blocked but dequeue still proceeds. in_ready rises the cycle after the dequeue.
- Latency: the earliest c_we is the cycle after the dequeue edge. Accept edge N, dequeue edge N+1, c_we high in the cycle after edge N+1, so the regfile write lands at edge N+2.
- There is no bypass path from input to output. Writes issue in strict FIFO order, with no coalescing of writes to the same register.
- chk_hit = chk_en & (chk_reg != 0) & (the output register holds c_we=1 with c_reg==chk_reg, OR any valid queue entry has reg==chk_reg).
  - Valid queue entries are the count entries from rd_ptr upward, with wrap.
  - A request on the in port in the same cycle is NOT included.
- chk_hit for chk_reg==0 is always 0.
- Pointer wrap: full and empty states are distinguished by count, not by pointer equality.

Test Plan:
- Reset, then single write (in_reg=3, in_data=0xDEADBEEF, one cycle): c_we=1 exactly one cycle, 2 cycles after accept, with c_reg=3 and c_writedatain=0xDEADBEEF. empty=1 afterwards.
- inc0 drop: in_reg=0, in_data=0x1234 accepted (in_ready=1) -> c_we never asserts, count stays 0, chk_reg=0 gives chk_hit=0.
- Fill and stall: with wr_stall=1, push regs 1,2,3,4 (data 0x10..0x13) -> count=4 and in_ready=0; a fifth push is not accepted. Release wr_stall -> c_we pulses on 4 consecutive cycles in order 1..4. in_ready=1 the cycle after the first dequeue.
- Simultaneous enqueue and dequeue: hold the queue at count=2 with continuous in_valid over 10 cycles and wr_stall=0 -> count stays constant, pointers wrap past DEPTH, and the output order matches the input order across the wrap.
- Hazard: queue reg 5 under wr_stall=1 -> chk_en=1, chk_reg=5 gives chk_hit=1 and chk_reg=6 gives 0. Release the stall -> chk_hit stays 1 while c_we=1 with c_reg=5, then drops to 0 once empty.
- Reset mid-operation: with 3 entries queued and c_we=1, assert resetn=0 for one edge -> next cycle c_we=0, count=0, empty=1, and none of the dropped entries ever appear on port c.
